ifetch_mem_ctrl: RTL and testbench

Responder side of the fetcher's instruction-memory request interface. It accepts a one-cycle fetch request carrying a PC and performs four sequential byte reads on the byte-wide RAM port. It assembles the bytes little-endian into a 32-bit instruction and returns it with a one-cycle done pulse. It sits between the fetcher and the RAM and supports abort on ROB misprediction flush.

---
 rtl/ifetch_mem_ctrl_pkg.sv | 35 +++
 rtl/ifetch_mem_ctrl_assembler.sv | 38 +++
 rtl/ifetch_mem_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_ifetch_mem_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_mem_ctrl_pkg.sv
// Shared definitions for the instruction-fetch memory controller and the byte assembler.
// Widths, FSM state encodings, boolean/zero constants and the byte-insert helper.
package ifetch_mem_ctrl_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int BYTE_WIDTH = 8;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [BYTE_WIDTH-1:0] byte_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic  FALSE     = 1'b0;
   localparam logic  TRUE      = 1'b1;
   localparam data_t ZERO_WORD = 32'h0000_0000;

   // Little-endian lane insert: byte idx lands in bits [8*idx+7 : 8*idx].
   function automatic data_t insert_byte(input data_t word, input logic [1:0] idx, input byte_t b);
      data_t res;
      res = word;
      case (idx)
         2'd0:    res[7:0]   = b;
         2'd1:    res[15:8]  = b;
         2'd2:    res[23:16] = b;
         2'd3:    res[31:24] = b;
         default: res        = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ifetch_mem_ctrl_assembler.sv
// mem_byte_assembler: 2-bit lane index plus 32-bit insert register with clear.
// word_ins_o is the register contents with the incoming byte already merged in.
module mem_byte_assembler
   import ifetch_mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic        ins_i,
   input  logic [7:0]  byte_i,
   output logic [1:0]  idx_o,
   output logic [31:0] word_ins_o
);

   logic [1:0] idx_q;
   data_t      word_q;

   assign word_ins_o = insert_byte(word_q, idx_q, byte_i);
   assign idx_o      = idx_q;

   // Lane index and partial word; clear has priority over insert.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q  <= 2'd0;
         word_q <= ZERO_WORD;
      end else if (en_i) begin
         if (clr_i) begin
            idx_q  <= 2'd0;
            word_q <= ZERO_WORD;
         end else if (ins_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word_ins_o;
         end
      end
   end

endmodule

// File: rtl/ifetch_mem_ctrl.sv
// Instruction-fetch responder: four sequential byte reads assembled little-endian into one word.
// Optional one-entry prefetch buffer enabled by defining IFETCH_PREFETCH_EN.
module ifetch_mem_ctrl
   import ifetch_mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        in_fetch_flag,
   input  logic [31:0] in_fetch_pc,
   output logic        out_fetch_flag,
   output logic [31:0] out_fetch_inst,
   input  logic        in_rob_xbp,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);

   state_e      state_q, state_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [1:0]  iss_off_q, iss_off_d;
   logic [1:0]  pipe_q, pipe_d;
   logic        flag_q, flag_d;
   logic [31:0] inst_q, inst_d;
   logic        asm_clr_s, asm_ins_s;
   logic [1:0]  asm_idx_s;
   logic [31:0] asm_word_ins_s;
   logic        last_cap_s;

`ifdef IFETCH_PREFETCH_EN
   logic        pf_valid_q, pf_valid_d;
   logic [31:0] pf_addr_q, pf_addr_d;
   logic [31:0] pf_data_q, pf_data_d;
   logic        pf_busy_q, pf_busy_d;
   logic        pf_hold_q, pf_hold_d;
   logic        arm_q, arm_d;
   logic [31:0] arm_addr_q, arm_addr_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic        hit_s, same_s;

   assign hit_s  = in_fetch_flag && pf_valid_q && (in_fetch_pc == pf_addr_q);
   assign same_s = in_fetch_flag && (in_fetch_pc == fetch_addr_q);
`endif

   mem_byte_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .en_i       (rdy),
      .clr_i      (asm_clr_s),
      .ins_i      (asm_ins_s),
      .byte_i     (mem_din),
      .idx_o      (asm_idx_s),
      .word_ins_o (asm_word_ins_s)
   );

   // pipe_q[1] marks an address issued two enabled edges ago, so mem_din now holds its byte.
   assign last_cap_s = pipe_q[1] && (asm_idx_s == 2'd3);

   assign out_fetch_flag = flag_q;
   assign out_fetch_inst = inst_q;
   assign mem_a          = mem_a_q;
   assign mem_dout       = 8'h00;
   assign mem_wr         = FALSE;

   // Next-state, address issue, capture and delivery decisions.
   always_comb begin
      state_d   = state_q;
      mem_a_d   = mem_a_q;
      iss_off_d = iss_off_q;
      pipe_d    = {pipe_q[0], FALSE};
      flag_d    = FALSE;
      inst_d    = inst_q;
      asm_clr_s = FALSE;
      asm_ins_s = pipe_q[1];
`ifdef IFETCH_PREFETCH_EN
      pf_valid_d   = pf_valid_q;
      pf_addr_d    = pf_addr_q;
      pf_data_d    = pf_data_q;
      pf_busy_d    = pf_busy_q;
      pf_hold_d    = pf_hold_q;
      arm_d        = arm_q;
      arm_addr_d   = arm_addr_q;
      fetch_addr_d = fetch_addr_q;
`endif
      if (in_rob_xbp) begin
         state_d   = IDLE;
         iss_off_d = 2'd0;
         pipe_d    = 2'b00;
         asm_clr_s = TRUE;
         asm_ins_s = FALSE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_fetch_flag) begin
                  mem_a_d   = in_fetch_pc;
                  iss_off_d = 2'd0;
                  pipe_d[0] = TRUE;
                  state_d   = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
            ISSUE: begin
               mem_a_d   = mem_a_q + 32'd1;
               iss_off_d = iss_off_q + 2'd1;
               pipe_d[0] = TRUE;
               if (iss_off_q == 2'd2) begin
                  state_d = DRAIN;
               end else begin
                  state_d = ISSUE;
               end
            end
            DRAIN: begin
               if (last_cap_s) begin
                  flag_d  = TRUE;
                  inst_d  = asm_word_ins_s;
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
`ifdef IFETCH_PREFETCH_EN
      // Prefetch overrides layered on top of the plain fetch sequence.
      if (in_rob_xbp) begin
         pf_valid_d = FALSE;
         pf_busy_d  = FALSE;
         pf_hold_d  = FALSE;
         arm_d      = FALSE;
      end else if (state_q == IDLE) begin
         if (hit_s) begin
            state_d    = IDLE;
            mem_a_d    = mem_a_q;
            pipe_d     = 2'b00;
            flag_d     = TRUE;
            inst_d     = pf_data_q;
            arm_d      = TRUE;
            arm_addr_d = in_fetch_pc + 32'd4;
         end else if (in_fetch_flag) begin
            fetch_addr_d = in_fetch_pc;
            pf_busy_d    = FALSE;
            pf_hold_d    = FALSE;
            arm_d        = FALSE;
         end else if (arm_q) begin
            state_d      = ISSUE;
            mem_a_d      = arm_addr_q;
            iss_off_d    = 2'd0;
            pipe_d       = 2'b01;
            fetch_addr_d = arm_addr_q;
            pf_busy_d    = TRUE;
            pf_hold_d    = FALSE;
            arm_d        = FALSE;
         end else begin
            arm_d = FALSE;
         end
      end else if (pf_busy_q && in_fetch_flag && !same_s) begin
         state_d      = ISSUE;
         mem_a_d      = in_fetch_pc;
         iss_off_d    = 2'd0;
         pipe_d       = 2'b01;
         asm_clr_s    = TRUE;
         asm_ins_s    = FALSE;
         flag_d       = FALSE;
         inst_d       = inst_q;
         fetch_addr_d = in_fetch_pc;
         pf_busy_d    = FALSE;
         pf_hold_d    = FALSE;
      end else if (pf_busy_q && last_cap_s && (state_q == DRAIN) && !(pf_hold_q || same_s)) begin
         flag_d     = FALSE;
         inst_d     = inst_q;
         pf_valid_d = TRUE;
         pf_addr_d  = fetch_addr_q;
         pf_data_d  = asm_word_ins_s;
         pf_busy_d  = FALSE;
      end else if (last_cap_s && (state_q == DRAIN)) begin
         arm_d      = TRUE;
         arm_addr_d = fetch_addr_q + 32'd4;
         pf_busy_d  = FALSE;
         pf_hold_d  = FALSE;
      end else if (pf_busy_q && same_s) begin
         pf_hold_d = TRUE;
      end else begin
         pf_hold_d = pf_hold_q;
      end
`endif
   end

   // State and output registers; everything freezes while rdy is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mem_a_q   <= ZERO_WORD;
         iss_off_q <= 2'd0;
         pipe_q    <= 2'b00;
         flag_q    <= FALSE;
         inst_q    <= ZERO_WORD;
      end else if (rdy) begin
         state_q   <= state_d;
         mem_a_q   <= mem_a_d;
         iss_off_q <= iss_off_d;
         pipe_q    <= pipe_d;
         flag_q    <= flag_d;
         inst_q    <= inst_d;
      end
   end

`ifdef IFETCH_PREFETCH_EN
   // Prefetch buffer and background-fetch bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pf_valid_q   <= FALSE;
         pf_addr_q    <= ZERO_WORD;
         pf_data_q    <= ZERO_WORD;
         pf_busy_q    <= FALSE;
         pf_hold_q    <= FALSE;
         arm_q        <= FALSE;
         arm_addr_q   <= ZERO_WORD;
         fetch_addr_q <= ZERO_WORD;
      end else if (rdy) begin
         pf_valid_q   <= pf_valid_d;
         pf_addr_q    <= pf_addr_d;
         pf_data_q    <= pf_data_d;
         pf_busy_q    <= pf_busy_d;
         pf_hold_q    <= pf_hold_d;
         arm_q        <= arm_d;
         arm_addr_q   <= arm_addr_d;
         fetch_addr_q <= fetch_addr_d;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_mem_ctrl.sv
// Self-checking bench for ifetch_mem_ctrl: directed and random fetches against a word/latency model.
// Prefetch-hit steps are included when IFETCH_PREFETCH_EN is defined.
module tb_ifetch_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        in_fetch_flag;
   logic [31:0] in_fetch_pc;
   logic        out_fetch_flag;
   logic [31:0] out_fetch_inst;
   logic        in_rob_xbp;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] prev_word;
   bit          req_pending;
   logic [7:0]  low_mem [4] = '{8'h13, 8'h05, 8'h10, 8'h00};

   ifetch_mem_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .in_fetch_flag  (in_fetch_flag),
      .in_fetch_pc    (in_fetch_pc),
      .out_fetch_flag (out_fetch_flag),
      .out_fetch_inst (out_fetch_inst),
      .in_rob_xbp     (in_rob_xbp),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      logic [7:0] h;
      if (a < 32'd4) h = low_mem[a[1:0]];
      else           h = (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      return h;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] pc);
      return {ram_byte(pc + 32'd3), ram_byte(pc + 32'd2), ram_byte(pc + 32'd1), ram_byte(pc)};
   endfunction

   // Synchronous RAM, enabled together with the rest of the system by rdy.
   always @(posedge clk) begin
      if (rdy) mem_din <= ram_byte(mem_a);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One fetch: eff counts enabled edges since the request was sampled (the sampling edge is 1).
   task automatic run_fetch(input logic [31:0] pc, input int stall_at, input int stall_len,
                            input int flush_at, input bit chain, input logic [31:0] chain_pc,
                            input string tag);
      int          eff;
      int          cyc;
      int          off;
      bit          flushed;
      logic [31:0] exp_w;
      exp_w = ref_word(pc);
      if (!req_pending) begin
         @(negedge clk);
         in_fetch_flag = 1'b1;
         in_fetch_pc   = pc;
      end
      req_pending = 1'b0;
      @(negedge clk);
      in_fetch_flag = 1'b0;
      eff = 1;
      cyc = 1;
      flushed = 1'b0;
      while (1) begin
         if (!flushed) begin
            off = (eff - 1 > 3) ? 3 : eff - 1;
            chk({tag, "_mem_a"}, mem_a, pc + 32'(off));
            chk({tag, "_flag"}, 32'(out_fetch_flag), 32'(eff == 6));
            chk({tag, "_inst"}, out_fetch_inst, (eff >= 6) ? exp_w : prev_word);
         end else begin
            chk({tag, "_noflag"}, 32'(out_fetch_flag), 32'd0);
            chk({tag, "_hold"}, out_fetch_inst, prev_word);
         end
         if (eff == 6 && !flushed && chain) begin
            prev_word     = exp_w;
            rdy           = 1'b1;
            in_rob_xbp    = 1'b0;
            in_fetch_flag = 1'b1;
            in_fetch_pc   = chain_pc;
            req_pending   = 1'b1;
            return;
         end
         if ((!flushed && eff == 7) || (flushed && cyc >= flush_at + 8) || cyc >= 60) break;
         rdy        = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
         in_rob_xbp = (cyc == flush_at);
         @(negedge clk);
         if (rdy) eff++;
         if (rdy && in_rob_xbp) flushed = 1'b1;
         in_rob_xbp = 1'b0;
         cyc++;
      end
      rdy = 1'b1;
      if (!flushed) prev_word = exp_w;
   endtask

   initial begin
      logic [31:0] rpc;
      int          mode;
      rst = 1'b0; rdy = 1'b1; in_fetch_flag = 1'b0; in_rob_xbp = 1'b0;
      in_fetch_pc = 32'h0; prev_word = 32'h0; req_pending = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_flag", 32'(out_fetch_flag), 32'd0);
      chk("rst_inst", out_fetch_inst, 32'h0);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_dout", 32'(mem_dout), 32'd0);
      chk("rst_wr", 32'(mem_wr), 32'd0);
      rst = 1'b1;

      run_fetch(32'h0000_0000, 0, 0, 0, 1'b0, 32'h0, "pc0");
      chk("pc0_word", prev_word, 32'h0010_0513);
      run_fetch(32'h0000_0100, 0, 0, 3, 1'b0, 32'h0, "flush3");
      run_fetch(32'h0000_0200, 0, 0, 0, 1'b0, 32'h0, "after_flush");
      run_fetch(32'h0000_0300, 2, 4, 0, 1'b0, 32'h0, "stall4");
      run_fetch(32'hFFFF_FFFD, 0, 0, 0, 1'b0, 32'h0, "wrap");
      run_fetch(32'h0000_0440, 0, 0, 5, 1'b0, 32'h0, "flush_b3");
      run_fetch(32'h0000_0500, 0, 0, 0, 1'b1, 32'h0000_0604, "b2b_a");
      run_fetch(32'h0000_0604, 0, 0, 0, 1'b0, 32'h0, "b2b_b");

      // Flush and request in the same cycle: the request is dropped.
      @(negedge clk);
      in_fetch_flag = 1'b1; in_fetch_pc = 32'h0000_0700; in_rob_xbp = 1'b1;
      @(negedge clk);
      in_fetch_flag = 1'b0; in_rob_xbp = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("drop_flag", 32'(out_fetch_flag), 32'd0);
         @(negedge clk);
      end
      chk("drop_inst", out_fetch_inst, prev_word);

      for (int i = 0; i < 8; i++) begin
         rpc  = $urandom;
         mode = $urandom_range(0, 2);
         run_fetch(rpc, (mode == 1) ? $urandom_range(1, 4) : 0, (mode == 1) ? $urandom_range(1, 4) : 0,
                   (mode == 2) ? $urandom_range(1, 5) : 0, 1'b0, 32'h0, "rand");
      end

      // Asynchronous reset in the middle of a fetch.
      @(negedge clk);
      in_fetch_flag = 1'b1; in_fetch_pc = 32'h8000_0010;
      @(negedge clk);
      in_fetch_flag = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_flag", 32'(out_fetch_flag), 32'd0);
      chk("arst_inst", out_fetch_inst, 32'h0);
      chk("arst_mem_a", mem_a, 32'h0);
      chk("arst_dout", 32'(mem_dout), 32'd0);
      chk("arst_wr", 32'(mem_wr), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      prev_word = 32'h0;
      for (int k = 0; k < 8; k++) begin
         chk("arst_noflag", 32'(out_fetch_flag), 32'd0);
         @(negedge clk);
      end
      run_fetch(32'h0000_0020, 0, 0, 0, 1'b0, 32'h0, "post_rst");

`ifdef IFETCH_PREFETCH_EN
      run_fetch(32'h0000_0000, 0, 0, 0, 1'b0, 32'h0, "pf_seed");
      repeat (8) @(negedge clk);
      in_fetch_flag = 1'b1; in_fetch_pc = 32'h0000_0004;
      @(negedge clk);
      in_fetch_flag = 1'b0;
      chk("pf_hit_flag", 32'(out_fetch_flag), 32'd1);
      chk("pf_hit_inst", out_fetch_inst, ref_word(32'h0000_0004));
      prev_word = ref_word(32'h0000_0004);
      @(negedge clk);
      chk("pf_hit_pulse", 32'(out_fetch_flag), 32'd0);
      run_fetch(32'h0000_0040, 0, 0, 0, 1'b0, 32'h0, "pf_miss");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
